// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   Byte FIFO between a UART receiver and a consumer. A byte is captured on
//   the rising edge of rx_done and presented at the head with first-word
//   fall-through timing. Bytes that arrive while the FIFO is full (with no
//   read in the same cycle) are dropped and latch a sticky overrun flag.
//
//   Optional feature macro: UART_RX_FIFO_ALMOST_FULL_EN
//     When defined, adds o_almost_full = (count >= AF_THRESH), registered
//     together with the count.
//
// Parameters
//   DEPTH      entries (power of two, >= 2)
//   AW         log2(DEPTH)
//   AF_THRESH  almost-full threshold, 1..DEPTH
//
// Ports
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   i_rx_data[7:0] received byte, valid while i_rx_done is high
//   i_rx_done      receiver done flag, rising edge writes one byte
//   i_flush        synchronous clear of the FIFO contents
//   i_rd_ready     consumer accepts the head byte
//   i_ovr_clr      clears the overrun flag
//   o_rd_data[7:0] head byte (don't-care when o_rd_valid is 0)
//   o_rd_valid     FIFO not empty
//   o_count[AW:0]  occupancy 0..DEPTH
//   o_full         occupancy equals DEPTH
//   o_overrun      sticky: a byte was dropped
//   o_almost_full  occupancy >= AF_THRESH (macro builds only)
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int AF_THRESH = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_done,
  input  logic          i_flush,
  input  logic          i_rd_ready,
  input  logic          i_ovr_clr,
  output logic [7:0]    o_rd_data,
  output logic          o_rd_valid,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_overrun
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  ,
  output logic          o_almost_full
`endif
);

  // Elaboration-time parameter sanity check.
  if (DEPTH < 2 || (1 << AW) != DEPTH || AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_param_err
    $error("uart_rx_fifo: illegal DEPTH/AW/AF_THRESH combination");
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic [AW:0] r_count;
  logic        r_rx_done_d;
  logic        r_armed;
  logic        r_overrun;

  logic        w_empty;
  logic        w_full;
  logic        w_wr_evt;
  logic        w_rd_evt;
  logic        w_wr_acc;
  logic        w_rd_acc;
  logic        w_drop;
  logic [AW:0] w_count_nxt;
  logic [AW:0] w_wptr_nxt;
  logic [AW:0] w_rptr_nxt;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // r_armed stays low after reset until rx_done has been seen low, so a
  // rx_done that is already high when reset releases cannot fake an edge.
  assign w_wr_evt = i_rx_done & ~r_rx_done_d & r_armed;
  assign w_rd_evt = ~w_empty & i_rd_ready;

  // A full FIFO still accepts a write when the head is consumed this cycle.
  // Flush discards both events and never counts as a drop.
  assign w_wr_acc = w_wr_evt & ~i_flush & (~w_full | w_rd_evt);
  assign w_rd_acc = w_rd_evt & ~i_flush;
  assign w_drop   = w_wr_evt & ~i_flush & w_full & ~w_rd_evt;

  always_comb begin
    w_count_nxt = r_count;
    w_wptr_nxt  = r_wptr;
    w_rptr_nxt  = r_rptr;
    if (i_flush) begin
      w_count_nxt = '0;
      w_wptr_nxt  = '0;
      w_rptr_nxt  = '0;
    end else begin
      if (w_wr_acc) w_wptr_nxt = r_wptr + (AW+1)'(1);
      if (w_rd_acc) w_rptr_nxt = r_rptr + (AW+1)'(1);
      unique case ({w_wr_acc, w_rd_acc})
        2'b10:   w_count_nxt = r_count + (AW+1)'(1);
        2'b01:   w_count_nxt = r_count - (AW+1)'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_rx_done_d <= 1'b0;
      r_armed     <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_wptr      <= w_wptr_nxt;
      r_rptr      <= w_rptr_nxt;
      r_count     <= w_count_nxt;
      r_rx_done_d <= i_rx_done;
      r_armed     <= r_armed | ~i_rx_done;
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop)         r_overrun <= 1'b1;
      else if (i_ovr_clr) r_overrun <= 1'b0;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr[AW-1:0]] <= i_rx_data;
  end

  assign o_rd_data  = r_mem[r_rptr[AW-1:0]];
  assign o_rd_valid = ~w_empty;
  assign o_count    = r_count;
  assign o_full     = w_full;
  assign o_overrun  = r_overrun;

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  logic r_almost_full;

  always_ff @(posedge clk) begin
    if (!rst_n) r_almost_full <= 1'b0;
    else        r_almost_full <= (w_count_nxt >= (AW+1)'(AF_THRESH));
  end

  assign o_almost_full = r_almost_full;
`endif

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of byte entries, power of two, minimum 2.
REQ-002 Parameter AW, default 4, address width, equals log2(DEPTH).
REQ-003 Parameter AF_THRESH, default 12, almost-full threshold in entries, range 1..DEPTH.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 rx_data  input  8  received byte from the UART receiver, valid while rx_done is high.
REQ-007 rx_done  input  1  receiver completion flag; only its rising edge is meaningful.
REQ-008 flush  input  1  synchronous FIFO clear request.
REQ-009 rd_ready  input  1  consumer accepts the head byte.
REQ-010 rd_data  output  8  head-of-FIFO byte (first-word fall-through).
REQ-011 rd_valid  output  1  rd_data holds a valid byte; equals not-empty.
REQ-012 count  output  AW+1  current occupancy, 0..DEPTH.
REQ-013 full  output  1  count equals DEPTH.
REQ-014 overrun  output  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-015 ovr_clr  input  1  clears overrun.
REQ-016 almost_full  output  1  count >= AF_THRESH (present only when the macro is defined).

Function
REQ-017 A write event SHALL occur in a cycle where rx_done is 1 and rx_done was 0 in the previous cycle (registered edge detector); a held-high rx_done SHALL produce exactly one write.
REQ-018 A read event SHALL occur in a cycle where rd_valid and rd_ready are both 1; rd_data SHALL advance to the next entry on the following cycle.
REQ-019 Read and write pointers SHALL be AW+1 bits wide; entries are addressed by the low AW bits; full = MSBs differ and low bits equal; empty = pointers equal; both pointers SHALL wrap naturally from DEPTH*2-1 to 0.
REQ-020 A write event SHALL be accepted if the FIFO is not full, or if it is full and a read event occurs in the same cycle; otherwise the byte SHALL be dropped and overrun set to 1 on the next cycle.
REQ-021 Simultaneous read and write SHALL leave count unchanged and preserve FIFO order.
REQ-022 A write into an empty FIFO SHALL make rd_valid 1 and rd_data equal to the written byte on the next cycle (one-cycle latency).
REQ-023 rd_ready while rd_valid is 0 SHALL have no effect.
REQ-024 flush SHALL set both pointers and count to 0 on the next cycle; a write or read event in the same cycle SHALL be discarded; overrun SHALL be unaffected.
REQ-025 ovr_clr SHALL clear overrun on the next cycle; if a drop occurs in the same cycle, set SHALL win and overrun remain 1.
REQ-026 Storage contents SHALL NOT be reset; rd_data is don't-care while rd_valid is 0.

Reset
REQ-027 With rst_n low at a clock edge: pointers 0, count 0, rd_valid 0, full 0, overrun 0, almost_full 0, edge-detector register 0.
REQ-028 Reset mid-operation SHALL discard all stored bytes; a rx_done already high when reset releases SHALL NOT cause a write until it falls and rises again.

Configuration
REQ-029 Macro UART_RX_FIFO_ALMOST_FULL_EN: when defined, port almost_full exists and equals (count >= AF_THRESH) registered with count; when undefined, the port and its logic are absent and all other behaviour is identical.

Verification
REQ-030 Reset, then 3 rx_done pulses with bytes 0x41,0x42,0x43, rd_ready=0 -> count=3, rd_valid=1, rd_data=0x41; then rd_ready=1 for 3 cycles -> 0x41,0x42,0x43 in order, count=0, rd_valid=0.
REQ-031 rx_done held high 10 cycles with 0x55 -> exactly one entry, count=1.
REQ-032 Fill 16 bytes 0x00..0x0F, then a 17th byte 0xAA with rd_ready=0 -> full=1, count=16, overrun=1, reading drains 0x00..0x0F with 0xAA absent; ovr_clr=1 -> overrun=0.
REQ-033 FIFO full, write 0xBB in the same cycle as a read -> count stays 16, overrun stays 0, 0xBB emerges last after 0x01..0x0F.
REQ-034 count=5 with flush=1 and a write edge in the same cycle -> count=0, rd_valid=0 next cycle; overrun unchanged.
REQ-035 Macro defined, AF_THRESH=12: write 11 bytes -> almost_full=0; 12th -> almost_full=1; one read -> almost_full=0.
